pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Parametrised controller for a Gowin PLL instantiated with dynamic charge-pump and loop-filter inputs (ICPSEL/LPFRES/LPFCAP) enabled.
- Sequences PLL reset, applies loop settings from a table of NUM_CFG entries, waits for and qualifies lock, and steps to the next entry when lock times out.
- On loss of lock it re-locks using the entry that last worked.
- Sits beside the HDMI PLL wrapper, clocked by the PLL's own reference clock; drives its reset/icpsel/lpfres/lpfcap and consumes its lock.

Parameters:
NUM_CFG, 4, number of loop-filter table entries (1..16)
CFG_TABLE, 44'h0, packed table; entry i = CFG_TABLE[11*i +: 11] = {lpfcap[1:0], lpfres[2:0], icpsel[5:0]}
RESET_CYCLES, 16, cycles pll_reset held high per attempt (>=1)
LOCK_TIMEOUT, 4096, cycles allowed in WAIT_LOCK+STABLE per attempt before advancing entry (>=8)
LOCK_STABLE, 256, consecutive synced-lock-high cycles required to declare locked (>=1)

Ports:
clkin  input  1  free-running reference clock (50 MHz); all logic on rising edge
reset  input  1  synchronous, active-high
restart  input  1  single-cycle pulse: restart search from entry 0
pll_lock  input  1  raw PLL lock, asynchronous; 2-FF synchronised internally (lock_s)
pll_reset  output  1  to PLL RESET
icpsel  output  6  to PLL ICPSEL
lpfres  output  3  to PLL LPFRES
lpfcap  output  2  to PLL LPFCAP
cfg_idx  output  IW=max(1,$clog2(NUM_CFG))  active table entry
locked  output  1  qualified lock
fail  output  1  all entries exhausted

Behaviour:
- Reset (wins over restart): state=RST_ASSERT, pll_reset=1, cfg_idx=0, {lpfcap,lpfres,icpsel}=entry 0, locked=0, fail=0, all counters 0, sync flops 0.
- All outputs registered. Loop-setting outputs change only in the cycle pll_reset rises or while it is high, never while it is low.
- RST_ASSERT: pll_reset=1; rst_cnt counts 0..RESET_CYCLES-1, then pll_reset=0 next cycle, timeout counter cleared, go WAIT_LOCK.
- WAIT_LOCK: to_cnt increments each cycle.
  - lock_s=1: go STABLE, stab_cnt=1.
  - to_cnt reaches LOCK_TIMEOUT-1: timeout.
- STABLE: to_cnt keeps counting, not cleared.
  - lock_s=1: stab_cnt increments; at stab_cnt==LOCK_STABLE, go LOCKED, locked=1.
  - lock_s=0: back to WAIT_LOCK.
  - Timeout is checked here too and has priority over the stable-count completion in the same cycle.
- Timeout (from WAIT_LOCK or STABLE):
  - cfg_idx<NUM_CFG-1: cfg_idx+1, load that entry, pll_reset=1, go RST_ASSERT.
  - cfg_idx==NUM_CFG-1: go FAIL.
- LOCKED: locked=1.
  - lock_s=0: locked=0 next cycle, pll_reset=1, go RST_ASSERT with cfg_idx unchanged; the entry is not advanced.
- FAIL: fail=1, pll_reset=1, locked=0; holds until reset or restart.
- restart in any state: next cycle state=RST_ASSERT, cfg_idx=0, entry 0 loaded, pll_reset=1, locked=0, fail=0, counters cleared.
- Latency: pll_lock rise to lock_s is 2 cycles; minimum pll_lock rise to locked is 2+LOCK_STABLE+1 cycles. pll_lock fall to locked=0 is 3 cycles.
- NUM_CFG=1: a timeout goes directly to FAIL.
- Counter widths are $clog2(param+1). No counter wraps; each saturates at its terminal state transition.

Optional Feature:
PLL_SUP_LOSS_CNT_EN
- Defined: adds output loss_cnt (8 bits), reset 0. It increments on each LOCKED->RST_ASSERT transition caused by lock_s=0, and saturates at 255. restart clears it.
- Undefined: port and logic absent; all other behaviour is identical.

Test Plan:
- Test parameters: NUM_CFG=3, RESET_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8. Table entries 0x001, 0x242, 0x7FF.
- pll_lock held high from reset release -> pll_reset low after 4 cycles; locked=1 at 2+8+1 cycles after lock_s qualifies; cfg_idx=0; icpsel=6'h01.
- pll_lock tied low -> cfg_idx steps 0->1->2, with pll_reset pulses of 4 cycles between 32-cycle waits. Then fail=1, pll_reset=1, outputs={2'b11,3'b111,6'h3F}. locked stays 0.
- Lock on entry 1 only (pll_lock high when cfg_idx==1 and pll_reset low) -> locked=1, cfg_idx=1, lpfres=3'b001, icpsel=6'h02.
- From LOCKED at cfg_idx=1, drop pll_lock for 1 cycle then restore -> locked=0 three cycles after the drop, 4-cycle reset, re-lock with cfg_idx still 1. With PLL_SUP_LOSS_CNT_EN, loss_cnt=1.
- Glitchy lock (pll_lock toggling every 5 cycles) -> locked never asserts; timeouts still fire every 32 cycles; fail=1 after entry 2.
- In FAIL, pulse restart together with reset -> reset state (cfg_idx=0, fail=0). Then restart alone -> fail=0, RST_ASSERT at entry 0 on the next cycle.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: PLL reset/loop-filter table sequencer with lock qualification; in clkin,reset,restart,pll_lock; out pll_reset,icpsel,lpfres,lpfcap,cfg_idx,locked,fail (+loss_cnt when PLL_SUP_LOSS_CNT_EN)
module pll_lock_supervisor #(
  parameter int NUM_CFG = 4,
  parameter logic [11*NUM_CFG-1:0] CFG_TABLE = '0,
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int LOCK_STABLE = 256,
  localparam int IW = NUM_CFG > 1 ? $clog2(NUM_CFG) : 1
) (
  input  logic          clkin,
  input  logic          reset,
  input  logic          restart,
  input  logic          pll_lock,
  output logic          pll_reset,
  output logic [5:0]    icpsel,
  output logic [2:0]    lpfres,
  output logic [1:0]    lpfcap,
  output logic [IW-1:0] cfg_idx,
  output logic          locked,
  output logic          fail
`ifdef PLL_SUP_LOSS_CNT_EN
  ,
  output logic [7:0]    loss_cnt
`endif
);
  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  typedef enum logic [2:0] {RST_ASSERT, WAIT_LOCK, STABLE, LOCKED, FAIL} state_t;
  state_t state, state_d;
  logic [1:0] sync;
  logic lock_s, timeout;
  logic [RW-1:0] rst_cnt, rst_d;
  logic [TW-1:0] to_cnt, to_d;
  logic [SW-1:0] stab_cnt, stab_d;
  logic [IW-1:0] idx_d;
  logic prst_d, lck_d, fail_d;
  logic [7:0] loss_q, loss_d;
  assign lock_s = sync[1];
  assign timeout = to_cnt == TW'(LOCK_TIMEOUT - 1);
  always_comb begin
    state_d = state;
    rst_d = rst_cnt;
    to_d = to_cnt;
    stab_d = stab_cnt;
    idx_d = cfg_idx;
    prst_d = pll_reset;
    lck_d = locked;
    fail_d = fail;
    loss_d = loss_q;
    case (state)
      RST_ASSERT: begin
        rst_d = rst_cnt == RW'(RESET_CYCLES - 1) ? '0 : rst_cnt + 1'b1;
        if (rst_cnt == RW'(RESET_CYCLES - 1)) begin
          to_d = '0;
          prst_d = 1'b0;
          state_d = WAIT_LOCK;
        end
      end
      WAIT_LOCK, STABLE: begin
        to_d = timeout ? to_cnt : to_cnt + 1'b1;
        if (timeout) begin
          prst_d = 1'b1;
          stab_d = '0;
          rst_d = '0;
          fail_d = cfg_idx == IW'(NUM_CFG - 1);
          idx_d = fail_d ? cfg_idx : cfg_idx + 1'b1;
          state_d = fail_d ? FAIL : RST_ASSERT;
        end else if (!lock_s) begin
          stab_d = '0;
          state_d = WAIT_LOCK;
        end else if (state == WAIT_LOCK) begin
          stab_d = SW'(1);
          state_d = STABLE;
        end else if (stab_cnt == SW'(LOCK_STABLE)) begin
          lck_d = 1'b1;
          state_d = LOCKED;
        end else begin
          stab_d = stab_cnt + 1'b1;
        end
      end
      LOCKED: begin
        if (!lock_s) begin
          lck_d = 1'b0;
          prst_d = 1'b1;
          rst_d = '0;
          stab_d = '0;
          loss_d = loss_q + {7'd0, loss_q != 8'hFF};
          state_d = RST_ASSERT;
        end
      end
      default: ;
    endcase
    if (restart) begin
      state_d = RST_ASSERT;
      idx_d = '0;
      prst_d = 1'b1;
      lck_d = 1'b0;
      fail_d = 1'b0;
      rst_d = '0;
      to_d = '0;
      stab_d = '0;
      loss_d = '0;
    end
  end
  always_ff @(posedge clkin) begin
    if (reset) begin
      state <= RST_ASSERT;
      sync <= '0;
      rst_cnt <= '0;
      to_cnt <= '0;
      stab_cnt <= '0;
      cfg_idx <= '0;
      pll_reset <= 1'b1;
      locked <= 1'b0;
      fail <= 1'b0;
      loss_q <= '0;
      {lpfcap, lpfres, icpsel} <= CFG_TABLE[10:0];
    end else begin
      state <= state_d;
      sync <= {sync[0], pll_lock};
      rst_cnt <= rst_d;
      to_cnt <= to_d;
      stab_cnt <= stab_d;
      cfg_idx <= idx_d;
      pll_reset <= prst_d;
      locked <= lck_d;
      fail <= fail_d;
      loss_q <= loss_d;
      {lpfcap, lpfres, icpsel} <= CFG_TABLE[11*int'(idx_d) +: 11];
    end
  end
`ifdef PLL_SUP_LOSS_CNT_EN
  assign loss_cnt = loss_q;
`endif
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: vector table, corner sequences and random lock stimulus against a reference model
module tb_pll_lock_supervisor;
  localparam int N = 3, RC = 4, LT = 32, LS = 8;
  localparam logic [32:0] TABLE = {11'h7FF, 11'h242, 11'h001};
  logic clkin = 1'b0;
  logic reset, restart, pll_lock;
  logic pll_reset, locked, fail;
  logic [5:0] icpsel;
  logic [2:0] lpfres;
  logic [1:0] lpfcap;
  logic [1:0] cfg_idx;
`ifdef PLL_SUP_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif
  logic [10:0] tbl [3];
  int errors = 0, checks = 0;
  int m_idx, m_rst_left, m_elapsed, m_run, m_loss;
  bit m_failed, m_locked, h1, h2;
  typedef struct {
    bit r, rs, pl;
    int n;
    bit p, l, f;
    int i;
    logic [10:0] c;
  } vec_t;
  vec_t tv[$];

  pll_lock_supervisor #(
    .NUM_CFG(N), .CFG_TABLE(TABLE), .RESET_CYCLES(RC),
    .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS)
  ) dut (
    .clkin(clkin), .reset(reset), .restart(restart), .pll_lock(pll_lock),
    .pll_reset(pll_reset), .icpsel(icpsel), .lpfres(lpfres), .lpfcap(lpfcap),
    .cfg_idx(cfg_idx), .locked(locked), .fail(fail)
`ifdef PLL_SUP_LOSS_CNT_EN
    , .loss_cnt(loss_cnt)
`endif
  );

  always #5 clkin = ~clkin;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_prst();
    return m_failed || m_rst_left > 0;
  endfunction

  task automatic m_clear();
    m_idx = 0;
    m_rst_left = RC;
    m_elapsed = 0;
    m_run = 0;
    m_loss = 0;
    m_failed = 0;
    m_locked = 0;
  endtask

  task automatic model_step(bit r, bit rs, bit pl);
    bit ls;
    ls = h2;
    if (r) begin
      h1 = 0;
      h2 = 0;
      m_clear();
      return;
    end
    h2 = h1;
    h1 = pl;
    if (rs) m_clear();
    else if (m_failed) ;
    else if (m_rst_left > 0) begin
      m_rst_left--;
      m_elapsed = 0;
      m_run = 0;
    end else if (m_locked) begin
      if (!ls) begin
        m_locked = 0;
        m_rst_left = RC;
        m_loss = m_loss < 255 ? m_loss + 1 : 255;
      end
    end else if (m_elapsed == LT - 1) begin
      m_run = 0;
      if (m_idx == N - 1) m_failed = 1;
      else begin
        m_idx++;
        m_rst_left = RC;
      end
    end else begin
      m_elapsed++;
      m_run = ls ? m_run + 1 : 0;
      if (m_run == LS + 1) m_locked = 1;
    end
  endtask

  task automatic cyc(bit r, bit rs, bit pl);
    reset = r;
    restart = rs;
    pll_lock = pl;
    @(posedge clkin);
    model_step(r, rs, pl);
    #1;
    chk("pll_reset", 32'(pll_reset), 32'(m_prst()));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("fail", 32'(fail), 32'(m_failed));
    chk("cfg_idx", 32'(cfg_idx), m_idx);
    chk("loop_cfg", 32'({lpfcap, lpfres, icpsel}), 32'(tbl[m_idx]));
`ifdef PLL_SUP_LOSS_CNT_EN
    chk("loss_cnt", 32'(loss_cnt), m_loss);
`endif
  endtask

  task automatic add(bit r, bit rs, bit pl, int n, bit p, bit l, bit f, int i, logic [10:0] c);
    vec_t v;
    v.r = r; v.rs = rs; v.pl = pl; v.n = n;
    v.p = p; v.l = l; v.f = f; v.i = i; v.c = c;
    tv.push_back(v);
  endtask

  initial begin
    int seen;
    bit pl;
    int seg;
    tbl[0] = 11'h001;
    tbl[1] = 11'h242;
    tbl[2] = 11'h7FF;
    reset = 1;
    restart = 0;
    pll_lock = 0;
    h1 = 0;
    h2 = 0;
    m_clear();
    add(1, 0, 1, 2,   1, 0, 0, 0, 11'h001);
    add(0, 0, 1, 3,   1, 0, 0, 0, 11'h001);
    add(0, 0, 1, 1,   0, 0, 0, 0, 11'h001);
    add(0, 0, 1, 8,   0, 0, 0, 0, 11'h001);
    add(0, 0, 1, 1,   0, 1, 0, 0, 11'h001);
    add(0, 0, 0, 2,   0, 1, 0, 0, 11'h001);
    add(0, 0, 0, 1,   1, 0, 0, 0, 11'h001);
    add(0, 0, 0, 4,   0, 0, 0, 0, 11'h001);
    add(0, 0, 0, 31,  0, 0, 0, 0, 11'h001);
    add(0, 0, 0, 1,   1, 0, 0, 1, 11'h242);
    add(0, 0, 0, 4,   0, 0, 0, 1, 11'h242);
    add(0, 0, 0, 32,  1, 0, 0, 2, 11'h7FF);
    add(0, 0, 0, 4,   0, 0, 0, 2, 11'h7FF);
    add(0, 0, 0, 31,  0, 0, 0, 2, 11'h7FF);
    add(0, 0, 0, 1,   1, 0, 1, 2, 11'h7FF);
    add(0, 0, 0, 5,   1, 0, 1, 2, 11'h7FF);
    add(1, 1, 0, 1,   1, 0, 0, 0, 11'h001);
    add(0, 0, 0, 107, 0, 0, 0, 2, 11'h7FF);
    add(0, 0, 0, 1,   1, 0, 1, 2, 11'h7FF);
    add(0, 1, 0, 1,   1, 0, 0, 0, 11'h001);
    add(0, 0, 0, 3,   1, 0, 0, 0, 11'h001);
    add(0, 0, 0, 1,   0, 0, 0, 0, 11'h001);
    foreach (tv[k]) begin
      repeat (tv[k].n) cyc(tv[k].r, tv[k].rs, tv[k].pl);
      chk($sformatf("v%0d_pll_reset", k), 32'(pll_reset), 32'(tv[k].p));
      chk($sformatf("v%0d_locked", k), 32'(locked), 32'(tv[k].l));
      chk($sformatf("v%0d_fail", k), 32'(fail), 32'(tv[k].f));
      chk($sformatf("v%0d_cfg_idx", k), 32'(cfg_idx), tv[k].i);
      chk($sformatf("v%0d_loop_cfg", k), 32'({lpfcap, lpfres, icpsel}), 32'(tv[k].c));
    end
    cyc(1, 0, 0);
    for (int i = 0; i < 400 && !locked; i++)
      cyc(0, 0, m_idx == 1 && m_rst_left == 0 && !m_failed);
    chk("entry1_lock", 32'({locked, cfg_idx, lpfres, icpsel}), 32'({1'b1, 2'd1, 3'b001, 6'h02}));
    cyc(0, 0, 0);
    chk("drop_c1_locked", 32'(locked), 1);
    cyc(0, 0, 1);
    chk("drop_c2_locked", 32'(locked), 1);
    cyc(0, 0, 1);
    chk("drop_c3_locked", 32'(locked), 0);
    chk("drop_c3_pll_reset", 32'(pll_reset), 1);
    chk("drop_c3_cfg_idx", 32'(cfg_idx), 1);
    for (int i = 0; i < 100 && !locked; i++) cyc(0, 0, 1);
    chk("relock_locked", 32'(locked), 1);
    chk("relock_cfg_idx", 32'(cfg_idx), 1);
`ifdef PLL_SUP_LOSS_CNT_EN
    chk("relock_loss_cnt", 32'(loss_cnt), 1);
`endif
    cyc(1, 0, 0);
    seen = 0;
    for (int i = 0; i < 115; i++) begin
      cyc(0, 0, ((i / 5) % 2) == 1);
      if (locked) seen++;
    end
    chk("glitch_never_locked", seen, 0);
    chk("glitch_fail", 32'(fail), 1);
    cyc(1, 0, 0);
    pl = 0;
    seg = 0;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        pl = $urandom_range(0, 1) == 1;
        seg = $urandom_range(1, 60);
      end
      seg--;
      cyc(0, $urandom_range(0, 499) == 0, pl);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
